// File: rtl/chrom_serial_loader.sv
// chrom_serial_loader: assembles a framed byte stream (header, payload,
// XOR checksum) into a chromosome word and commits it atomically once the
// checksum matches. The committed word only changes on a good frame.
module chrom_serial_loader #(
    parameter int                   CHROM_W     = 86,
    parameter logic [7:0]           HDR_BYTE    = 8'hA5,
    parameter int                   TIMEOUT_CYC = 100000,
    parameter logic [CHROM_W-1:0]   RESET_CHROM = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [CHROM_W-1:0] chrom,
    output logic               chrom_update,
    output logic               frame_err,
    output logic [1:0]         err_code,
    output logic               busy
);

    localparam int NBYTES = (CHROM_W + 7) / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;
    localparam logic [1:0] ST_COMMIT  = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         csum_q, csum_d;
    logic [CHROM_W-1:0] shadow_q, shadow_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [CHROM_W-1:0] chrom_q, chrom_d;
    logic               upd_q, upd_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic               accept;

    // Handshake: the loader stalls the source only during the commit hold-off.
    always_comb begin
        in_ready = (state_q != ST_COMMIT);
        accept   = in_valid && in_ready;
    end

    // Frame sequencing, payload assembly, checksum and inter-byte timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        csum_d   = csum_q;
        shadow_d = shadow_q;
        to_d     = to_q;
        chrom_d  = chrom_q;
        upd_d    = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;

        case (state_q)
            ST_IDLE: begin
                to_d = '0;
                // Anything that is not a header is line noise and is dropped.
                if (accept && (in_data == HDR_BYTE)) begin
                    state_d = ST_PAYLOAD;
                    cnt_d   = '0;
                    csum_d  = '0;
                    code_d  = ERR_NONE;
                end
            end

            ST_PAYLOAD: begin
                if (accept) begin
                    // Bits of the last byte beyond CHROM_W are padding and
                    // are not stored, but still feed the checksum.
                    for (int k = 0; k < NBYTES; k++) begin
                        for (int b = 0; b < 8; b++) begin
                            if ((8 * k + b) < CHROM_W) begin
                                if (cnt_q == CNT_W'(k)) begin
                                    shadow_d[8 * k + b] = in_data[b];
                                end
                            end
                        end
                    end
                    csum_d = csum_q ^ in_data;
                    to_d   = '0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    to_d    = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            ST_CHECK: begin
                if (accept) begin
                    to_d = '0;
                    if (in_data == csum_q) begin
                        chrom_d = shadow_q;
                        upd_d   = 1'b1;
                        state_d = ST_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CSUM;
                        state_d = ST_IDLE;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    to_d    = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            ST_COMMIT: begin
                // One-cycle hold-off so downstream sees the new word settle.
                state_d = ST_IDLE;
                to_d    = '0;
            end

            default: begin
                state_d = ST_IDLE;
                to_d    = '0;
            end
        endcase
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            csum_q   <= '0;
            shadow_q <= '0;
            to_q     <= '0;
            chrom_q  <= RESET_CHROM;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
            shadow_q <= shadow_d;
            to_q     <= to_d;
            chrom_q  <= chrom_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    // Output mapping.
    always_comb begin
        chrom        = chrom_q;
        chrom_update = upd_q;
        frame_err    = err_q;
        err_code     = code_q;
        busy         = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_chrom_serial_loader.sv
// Bench for chrom_serial_loader: directed frames from the test plan, then
// random frames, noise, gaps, timeouts and resets against a frame-level model.
module tb_chrom_serial_loader;

    localparam int         CHROM_W = 12;
    localparam int         NBYTES  = (CHROM_W + 7) / 8;
    localparam int         TO_CYC  = 16;
    localparam logic [7:0] HDR     = 8'hA5;

    logic               clk;
    logic               rst_n;
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic [CHROM_W-1:0] chrom;
    logic               chrom_update;
    logic               frame_err;
    logic [1:0]         err_code;
    logic               busy;

    int total = 0;
    int bad   = 0;

    chrom_serial_loader #(
        .CHROM_W    (CHROM_W),
        .HDR_BYTE   (HDR),
        .TIMEOUT_CYC(TO_CYC),
        .RESET_CHROM('0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .chrom       (chrom),
        .chrom_update(chrom_update),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: frame-level view (collected bytes, hold-off, idle gap).
    logic [CHROM_W-1:0] m_chrom;
    logic               m_upd;
    logic               m_err;
    logic [1:0]         m_code;
    logic               m_infr;
    logic               m_hold;
    int                 m_idle;
    logic [7:0]         m_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CHROM_W-1:0] pack_frame();
        logic [CHROM_W-1:0] e;
        e = '0;
        for (int i = 0; i < m_q.size(); i++)
            for (int b = 0; b < 8; b++)
                if (8 * i + b < CHROM_W) e[8 * i + b] = m_q[i][b];
        return e;
    endfunction

    function automatic logic [7:0] xor_frame();
        logic [7:0] x;
        x = 8'h00;
        foreach (m_q[i]) x ^= m_q[i];
        return x;
    endfunction

    task automatic model_edge(input logic v, input logic [7:0] d, input logic r, output logic acc);
        acc = r && v && !m_hold;
        if (!r) begin
            m_chrom = '0; m_upd = 0; m_err = 0; m_code = 2'b00;
            m_infr = 0; m_hold = 0; m_idle = 0; m_q.delete();
        end else begin
            m_upd = 0;
            m_err = 0;
            if (m_hold) begin
                m_hold = 0;
            end else if (!m_infr) begin
                if (acc && d == HDR) begin
                    m_infr = 1; m_q.delete(); m_code = 2'b00; m_idle = 0;
                end
            end else if (acc) begin
                m_idle = 0;
                if (m_q.size() < NBYTES) begin
                    m_q.push_back(d);
                end else if (d == xor_frame()) begin
                    m_chrom = pack_frame(); m_upd = 1; m_hold = 1; m_infr = 0;
                end else begin
                    m_err = 1; m_code = 2'b01; m_infr = 0;
                end
            end else if (m_idle == TO_CYC - 1) begin
                m_err = 1; m_code = 2'b10; m_infr = 0; m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r, output logic acc);
        logic exp_ready;
        in_valid = v;
        in_data  = d;
        rst_n    = r;
        @(posedge clk);
        model_edge(v, d, r, acc);
        #1;
        exp_ready = !m_hold;
        chk("chrom", chrom, m_chrom);
        chk("chrom_update", chrom_update, m_upd);
        chk("frame_err", frame_err, m_err);
        chk("err_code", err_code, m_code);
        chk("busy", busy, m_infr || m_hold);
        chk("in_ready", in_ready, exp_ready);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, a);
    endtask

    task automatic send(input logic [7:0] b, input bit gaps);
        logic a;
        int   tries;
        if (gaps) idle($urandom_range(0, 2));
        a = 0;
        tries = 0;
        while (!a && tries < 4) begin
            step(1'b1, b, 1'b1, a);
            tries++;
        end
        chk("send_accepted", a, 1'b1);
    endtask

    task automatic send_frame(input logic [CHROM_W-1:0] w, input logic [7:0] pad,
                              input logic [7:0] corrupt, input bit gaps);
        logic [8*NBYTES-1:0] full;
        logic [7:0]          x;
        full = {pad, {(8*NBYTES-CHROM_W){1'b0}}, w} ;
        full = (8*NBYTES)'(w) | ((8*NBYTES)'(pad) << CHROM_W);
        x = 8'h00;
        send(HDR, gaps);
        for (int k = 0; k < NBYTES; k++) begin
            send(full[8*k +: 8], gaps);
            x ^= full[8*k +: 8];
        end
        send(x ^ corrupt, gaps);
    endtask

    initial begin
        logic a;
        in_valid = 0; in_data = 0; rst_n = 0;
        m_chrom = '0; m_upd = 0; m_err = 0; m_code = 0;
        m_infr = 0; m_hold = 0; m_idle = 0;

        step(1'b0, 8'h00, 1'b0, a);
        step(1'b0, 8'h00, 1'b0, a);
        chk("rst_chrom", chrom, 12'h000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_code", err_code, 2'b00);
        chk("rst_ready", in_ready, 1'b1);
        idle(2);

        // Good frame
        send(8'hA5, 0); send(8'h34, 0); send(8'h0C, 0); send(8'h38, 0);
        chk("good_chrom", chrom, 12'hC34);
        chk("good_upd", chrom_update, 1'b1);
        chk("good_ready_low", in_ready, 1'b0);
        chk("good_code", err_code, 2'b00);
        idle(1);
        chk("good_upd_end", chrom_update, 1'b0);
        chk("good_ready_back", in_ready, 1'b1);

        // Padding bits dropped
        send(8'hA5, 0); send(8'h34, 0); send(8'hFC, 0); send(8'hC8, 0);
        chk("pad_chrom", chrom, 12'hC34);
        chk("pad_upd", chrom_update, 1'b1);
        idle(1);

        // Bad checksum
        send(8'hA5, 0); send(8'h11, 0); send(8'h02, 0); send(8'h00, 0);
        chk("bad_err", frame_err, 1'b1);
        chk("bad_code", err_code, 2'b01);
        chk("bad_chrom", chrom, 12'hC34);
        chk("bad_upd", chrom_update, 1'b0);
        chk("bad_busy", busy, 1'b0);
        idle(1);
        chk("bad_err_end", frame_err, 1'b0);

        // Noise then resync
        send(8'h00, 0); send(8'hFF, 0);
        send(8'hA5, 0); send(8'h55, 0); send(8'h0A, 0); send(8'h5F, 0);
        chk("resync_chrom", chrom, 12'hA55);
        chk("resync_code", err_code, 2'b00);
        idle(1);

        // Timeout
        send(8'hA5, 0); send(8'h12, 0);
        idle(TO_CYC - 1);
        chk("to_no_err_yet", frame_err, 1'b0);
        idle(1);
        chk("to_err", frame_err, 1'b1);
        chk("to_code", err_code, 2'b10);
        chk("to_chrom", chrom, 12'hA55);
        chk("to_busy", busy, 1'b0);
        send(8'hA5, 0); send(8'h34, 0); send(8'h0C, 0); send(8'h38, 0);
        chk("to_after_chrom", chrom, 12'hC34);
        idle(1);

        // Reset mid-frame
        send(8'hA5, 0); send(8'h12, 0);
        step(1'b0, 8'h00, 1'b0, a);
        chk("midrst_chrom", chrom, 12'h000);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_code", err_code, 2'b00);
        send(8'hA5, 0); send(8'h34, 0); send(8'h0C, 0); send(8'h38, 0);
        chk("midrst_after", chrom, 12'hC34);

        // Random traffic
        for (int it = 0; it < 300; it++) begin
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: send_frame(CHROM_W'($urandom), 8'($urandom), 8'h00, $urandom_range(0, 1) == 1);
                4:          send_frame(CHROM_W'($urandom), 8'($urandom), 8'($urandom_range(1, 255)), 1);
                5:          send(8'($urandom), 1);
                6: begin
                    send(HDR, 1);
                    for (int k = 0; k < $urandom_range(0, NBYTES); k++) send(8'($urandom), 1);
                    idle($urandom_range(TO_CYC - 2, TO_CYC + 2));
                end
                7: idle($urandom_range(0, 5));
                8: begin
                    send(HDR, 1);
                    if ($urandom_range(0, 1) == 1) send(8'($urandom), 1);
                    step(1'($urandom), 8'($urandom), 1'b0, a);
                end
                default: begin
                    // header bytes inside payload are data
                    send_frame({HDR[3:0], HDR}, 8'($urandom), 8'h00, 0);
                end
            endcase
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
